sequential_circular_shift_controller: RTL and testbench
=======================================================

SEQUENTIAL_CIRCULAR_SHIFT_CONTROLLER -- requirements
Module: sequential_circular_shift_controller

Interface
REQ-001 SHALL have parameter W, default 8, data width; legal values are powers of two, at least 2.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, controller can accept a request.
REQ-006 SHALL have port in_data, input, W, word to rotate.
REQ-007 SHALL have port in_shift, input, $clog2(W), rotate amount in bits.
REQ-008 SHALL have port in_dir, input, 1, rotate direction: 0 = left, 1 = right.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out_data, output, W, rotated word.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready high only in IDLE, and SHALL drive out_valid high only in DONE.
REQ-015 SHALL accept a request on a rising edge with in_valid && in_ready, capturing in_data, in_shift and in_dir.
REQ-016 SHALL, on accept with an effective amount of 0, go to DONE holding in_data unchanged; otherwise it SHALL go to BUSY with a remaining count equal to the effective amount.
REQ-017 SHALL, on each BUSY edge, rotate the working register by exactly one bit in the effective direction and decrement the remaining count; it SHALL enter DONE on the edge where the count reaches 0.
REQ-018 SHALL raise out_valid in the cycle after accept edge + s edges, where s is the effective amount, so that s = 0 gives out_valid in the cycle right after accept.
REQ-019 SHALL hold out_data stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-020 SHALL NOT overlap requests: there is no accept in the edge that leaves DONE, so the next accept is possible one cycle later at the earliest.
REQ-021 SHALL make in_valid, in_data, in_shift and in_dir don't-care outside IDLE.
REQ-022 SHALL make the final result bit-identical to the combinational rotate: {x[W-1-s:0], x[W-1:W-s]} for left and {x[s-1:0], x[W-1:s]} for right.
REQ-023 SHALL treat the effective amount and direction as in_shift and in_dir, except as modified by REQ-027.

Reset
REQ-024 SHALL, with rst high at an edge, enter IDLE, clear out_data and the remaining count to 0, set out_valid = 0 and busy = 0, and set in_ready = 1 from the next cycle.
REQ-025 SHALL let reset abort an operation in BUSY or DONE, discarding the result with no out_valid pulse.
REQ-026 SHALL give reset priority over every handshake in the same edge.

Configuration
REQ-027 SHALL support macro CIRCULAR_SHIFT_SHORTEST_PATH_EN; when it is defined and in_shift > W/2, the request SHALL execute as a rotate of W - in_shift in the opposite direction, for a worst-case latency of W/2 BUSY cycles.
REQ-028 SHALL, without CIRCULAR_SHIFT_SHORTEST_PATH_EN, execute in_shift single-bit steps in in_dir, for a worst-case latency of W-1 BUSY cycles; out_data is identical in both builds.

Structure
REQ-029 SHALL place in shared package circular_shift_pkg the direction enum (DIR_LEFT = 0, DIR_RIGHT = 1) and the FSM state enum (IDLE, BUSY, DONE).
REQ-030 SHALL implement the one-bit rotate as combinational sub-module circular_shift_step (parameter W; ports: data in, dir, data out), instantiated once.

Verification
REQ-031 SHALL cover: W=8, 10110101 left 3 -> 10101101, out_valid exactly 3 cycles after the accept cycle.
REQ-032 SHALL cover: W=8, 10110101 right 3 -> 10110110; 01110000 left 3 -> 10000011.
REQ-033 SHALL cover: W=8, 11111111 or 00000000 with shift 0 -> unchanged value, out_valid in the cycle after accept.
REQ-034 SHALL cover: W=8, 10000000 left 7 -> 01000000, with 7 BUSY cycles without the macro and 1 BUSY cycle with it.
REQ-035 SHALL cover: out_ready held low for 5 cycles in DONE -> out_data and out_valid stable and in_ready low; release -> IDLE on the next edge.
REQ-036 SHALL cover: rst asserted in the 2nd BUSY cycle of a left 5 -> IDLE, out_valid never asserted, and a following 00100110 right 3 -> 11000100.

Source files
------------

// File: rtl/circular_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circular_shift_pkg
//  Description : Shared types for the sequential circular shift controller:
//                rotate direction and controller FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package circular_shift_pkg;

   // Rotate direction as presented on in_dir
   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Controller FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : circular_shift_pkg
`default_nettype wire

// File: rtl/circular_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : circular_shift_step
//  Description : Combinational single-bit rotate of a W-bit word, left or
//                right selected by dir.
//  Revision    : 1.0 - initial release
// ============================================================================
module circular_shift_step
   import circular_shift_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] data_in,
   input  logic         dir,
   output logic [W-1:0] data_out
);

   // Rotate by exactly one bit position in the requested direction
   always_comb begin
      if (dir == DIR_RIGHT) begin
         data_out = {data_in[0], data_in[W-1:1]};
      end else begin
         data_out = {data_in[W-2:0], data_in[W-1]};
      end
   end

endmodule : circular_shift_step
`default_nettype wire

// File: rtl/sequential_circular_shift_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_circular_shift_controller
//  Description : Rotates a W-bit word by in_shift bits, one bit per clock,
//                behind a valid/ready request and result handshake.
//                Optional macro CIRCULAR_SHIFT_SHORTEST_PATH_EN: amounts
//                above W/2 are executed as W - in_shift steps in the
//                opposite direction (same result, shorter latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module sequential_circular_shift_controller
   import circular_shift_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic [$clog2(W)-1:0] in_shift,
   input  logic                 in_dir,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic                 busy
);

   localparam int                   c_SHIFT_W   = $clog2(W);
   localparam logic [c_SHIFT_W-1:0] c_ZERO_SHIFT = '0;
   localparam logic [c_SHIFT_W-1:0] c_ONE_SHIFT  = c_SHIFT_W'(1);
`ifdef CIRCULAR_SHIFT_SHORTEST_PATH_EN
   localparam logic [c_SHIFT_W-1:0] c_HALF_SHIFT = c_SHIFT_W'(W / 2);
`endif

   state_e               r_state;
   state_e               w_state_next;
   logic [W-1:0]         r_data;
   logic [c_SHIFT_W-1:0] r_count;
   dir_e                 r_dir;
   logic [W-1:0]         w_step_data;
   logic [c_SHIFT_W-1:0] w_eff_shift;
   dir_e                 w_eff_dir;
   logic                 w_accept;

   assign w_accept = in_valid && in_ready;
   assign out_data = r_data;

   // Effective step count and direction for an incoming request
   always_comb begin
      w_eff_shift = in_shift;
      w_eff_dir   = dir_e'(in_dir);
`ifdef CIRCULAR_SHIFT_SHORTEST_PATH_EN
      if (in_shift > c_HALF_SHIFT) begin
         // W is a power of two, so W - in_shift wraps to 0 - in_shift
         w_eff_shift = c_ZERO_SHIFT - in_shift;
         w_eff_dir   = dir_e'(~in_dir);
      end
`endif
   end

   // Single-bit rotator shared by every BUSY step
   circular_shift_step #(
      .W (W)
   ) u_step (
      .data_in  (r_data),
      .dir      (r_dir),
      .data_out (w_step_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = (w_eff_shift == c_ZERO_SHIFT) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (r_count == c_ONE_SHIFT) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the current state
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      busy      = (r_state != IDLE);
   end

   // Working register and remaining-step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_count <= '0;
         r_dir   <= DIR_LEFT;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_data  <= in_data;
                  r_count <= w_eff_shift;
                  r_dir   <= w_eff_dir;
               end
            end
            BUSY: begin
               r_data  <= w_step_data;
               r_count <= r_count - c_ONE_SHIFT;
            end
            default: begin
               // DONE holds the result until the consumer takes it
            end
         endcase
      end
   end

endmodule : sequential_circular_shift_controller
`default_nettype wire

// File: tb/tb_sequential_circular_shift_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequential_circular_shift_controller
//  Description : Directed, table-driven bench for the sequential circular
//                shift controller (W = 8), plus hand-written sequences for
//                result backpressure and reset abort. Expected latencies
//                follow CIRCULAR_SHIFT_SHORTEST_PATH_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_circular_shift_controller;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [2:0]   in_shift;
   logic         in_dir;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [7:0] data;
      logic [2:0] shift;
      logic       dir;
      logic [7:0] exp;
      int         lat;
   } vec_t;

   vec_t vecs [9];

   sequential_circular_shift_controller #(
      .W (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for in_ready, then present one request for one edge
   task automatic start_op(input logic [7:0] d, input logic [2:0] s, input logic dr, input string name);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_ready_before_accept"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      in_shift = s;
      in_dir   = dr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_shift = 3'($urandom);
      in_dir   = 1'($urandom);
   endtask

   // Count cycles after the accept edge until out_valid (bounded)
   task automatic wait_done(output int lat, output int bad_cycles);
      lat        = 0;
      bad_cycles = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready || !busy) bad_cycles++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int bad;
      int seen;
      logic [7:0] held;

      vecs[0] = '{8'b10110101, 3'd3, 1'b0, 8'b10101101, 3};
      vecs[1] = '{8'b10110101, 3'd3, 1'b1, 8'b10110110, 3};
      vecs[2] = '{8'b01110000, 3'd3, 1'b0, 8'b10000011, 3};
      vecs[3] = '{8'b11111111, 3'd0, 1'b0, 8'b11111111, 0};
      vecs[4] = '{8'b00000000, 3'd0, 1'b1, 8'b00000000, 0};
`ifdef CIRCULAR_SHIFT_SHORTEST_PATH_EN
      vecs[5] = '{8'b10000000, 3'd7, 1'b0, 8'b01000000, 1};
      vecs[6] = '{8'b00000001, 3'd5, 1'b1, 8'b00001000, 3};
`else
      vecs[5] = '{8'b10000000, 3'd7, 1'b0, 8'b01000000, 7};
      vecs[6] = '{8'b00000001, 3'd5, 1'b1, 8'b00001000, 5};
`endif
      vecs[7] = '{8'b00111100, 3'd4, 1'b0, 8'b11000011, 4};
      vecs[8] = '{8'b10010110, 3'd1, 1'b1, 8'b01001011, 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shift  = '0;
      in_dir    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready",  in_ready,  1);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy",      busy,      0);
      check("reset_out_data",  out_data,  0);
      rst = 1'b0;

      // Table-driven rotations with the consumer always ready
      for (int i = 0; i < 9; i++) begin
         start_op(vecs[i].data, vecs[i].shift, vecs[i].dir, $sformatf("v%0d", i));
         wait_done(lat, bad);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_busy_flags", i), bad, 0);
         check($sformatf("v%0d_out_valid", i), out_valid, 1);
         check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp);
         @(posedge clk); #1;
         check($sformatf("v%0d_idle_after", i), in_ready, 1);
         check($sformatf("v%0d_valid_drop", i), out_valid, 0);
      end

      // Result backpressure: DONE holds for 5 cycles, new requests ignored
      out_ready = 1'b0;
      start_op(8'b10110101, 3'd3, 1'b0, "bp");
      wait_done(lat, bad);
      check("bp_latency", lat, 3);
      held = out_data;
      check("bp_out_data", held, 8'b10101101);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      in_shift = 3'd1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_c%0d_valid", c), out_valid, 1);
         check($sformatf("bp_c%0d_data", c), out_data, held);
         check($sformatf("bp_c%0d_in_ready", c), in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_idle",  in_ready,  1);
      check("bp_release_valid", out_valid, 0);
      check("bp_release_busy",  busy,      0);

      // Reset in the 2nd BUSY cycle of a left-5 aborts with no result
      seen = 0;
      start_op(8'b10110101, 3'd5, 1'b0, "abort");
      if (out_valid) seen++;
      @(posedge clk); #1;
      if (out_valid) seen++;
      check("abort_busy_before_rst", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_busy",     busy,     0);
      check("abort_out_data", out_data, 0);
      for (int c = 0; c < 8; c++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check("abort_no_out_valid", seen, 0);

      start_op(8'b00100110, 3'd3, 1'b1, "post");
      wait_done(lat, bad);
      check("post_latency",  lat,      3);
      check("post_out_data", out_data, 8'b11000100);
      @(posedge clk); #1;
      check("post_idle", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_sequential_circular_shift_controller
`default_nettype wire
